// File: rtl/skewed_feeder_pkg.sv
// Shared types and sizing helpers for the skewed, double-buffered tile feeder.
package skewed_feeder_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FULL,
    BANK_DRAIN
  } bank_state_t;

  typedef enum logic {
    ST_IDLE,
    ST_DRAIN
  } drain_state_t;

  // Width of the drain step counter: holds 0 .. ROWS+DEPTH-2, never below 1 bit.
  function automatic int step_w(input int rows, input int depth);
    int n;
    n = rows + depth - 1;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int idx_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/skewed_tile_feeder_tile_bank.sv
// One ROWS x DEPTH tile store: whole-tile write, independent per-row indexed read.
module tile_bank #(
  parameter int ROWS  = 8,
  parameter int DEPTH = 8,
  parameter int BITS  = 8,
  parameter int IW    = 3
) (
  input  logic            i_clk,
  input  logic            i_we,
  input  logic [BITS-1:0] i_wdata  [ROWS][DEPTH],
  input  logic [IW-1:0]   i_rd_idx [ROWS],
  output logic [BITS-1:0] o_rdata  [ROWS]
);

  logic [BITS-1:0] r_mem [ROWS][DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem <= i_wdata;
    end
  end

  for (genvar g = 0; g < ROWS; g++) begin : g_rd
    if (DEPTH == 1) begin : g_single
      assign o_rdata[g] = r_mem[g][0];
    end else begin : g_multi
      assign o_rdata[g] = r_mem[g][i_rd_idx[g]];
    end
  end

endmodule

// File: rtl/skewed_tile_feeder.sv
// Double-buffered tile feeder: loads a whole tile per handshake and drains it
// row-parallel with row r delayed by r steps, chaining banks without a bubble.
module skewed_tile_feeder
  import skewed_feeder_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int DEPTH = 8,
  parameter int BITS  = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_load_valid,
  output logic            o_load_ready,
  input  logic [BITS-1:0] i_load_data [ROWS][DEPTH],
  input  logic            i_en,
  output logic [BITS-1:0] o_out_data  [ROWS],
  output logic [ROWS-1:0] o_out_valid,
  output logic            o_busy,
  output logic            o_done,
  output drain_state_t    o_dbg_state
);

  // Load handshake: the tile is taken on a rising edge where i_load_valid and
  // o_load_ready are both high; o_load_ready depends on registered state only.

  localparam int TW = step_w(ROWS, DEPTH);
  localparam int IW = idx_w(DEPTH);
  localparam logic [TW-1:0] LAST_T = TW'(DEPTH + ROWS - 2);

  bank_state_t     r_bank_st [2];
  logic            r_wr_sel;
  logic            r_rd_sel;
  logic [TW-1:0]   r_t;
  drain_state_t    r_state;
  logic [BITS-1:0] r_out_data [ROWS];
  logic [ROWS-1:0] r_out_valid;
  logic            r_done;

  logic            w_load;
  logic [1:0]      w_we;
  logic [ROWS-1:0] w_row_vld;
  logic [IW-1:0]   w_idx   [ROWS];
  logic [BITS-1:0] w_rd0   [ROWS];
  logic [BITS-1:0] w_rd1   [ROWS];
  logic [BITS-1:0] w_rd_sel[ROWS];
  int              w_diff;

  assign o_load_ready = (r_bank_st[r_wr_sel] == BANK_EMPTY);
  assign w_load       = i_load_valid && o_load_ready;
  assign w_we[0]      = w_load && !r_wr_sel;
  assign w_we[1]      = w_load &&  r_wr_sel;

  // Row r reads element t-r; the signed difference keeps the skew window exact.
  always_comb begin
    w_diff    = 0;
    w_row_vld = '0;
    for (int r = 0; r < ROWS; r++) begin
      w_diff       = int'(r_t) - r;
      w_row_vld[r] = (w_diff >= 0) && (w_diff < DEPTH);
      w_idx[r]     = w_row_vld[r] ? w_diff[IW-1:0] : '0;
      w_rd_sel[r]  = r_rd_sel ? w_rd1[r] : w_rd0[r];
    end
  end

  tile_bank #(.ROWS(ROWS), .DEPTH(DEPTH), .BITS(BITS), .IW(IW)) u_bank0 (
    .i_clk    (i_clk),
    .i_we     (w_we[0]),
    .i_wdata  (i_load_data),
    .i_rd_idx (w_idx),
    .o_rdata  (w_rd0)
  );

  tile_bank #(.ROWS(ROWS), .DEPTH(DEPTH), .BITS(BITS), .IW(IW)) u_bank1 (
    .i_clk    (i_clk),
    .i_we     (w_we[1]),
    .i_wdata  (i_load_data),
    .i_rd_idx (w_idx),
    .o_rdata  (w_rd1)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_bank_st[0] <= BANK_EMPTY;
      r_bank_st[1] <= BANK_EMPTY;
      r_wr_sel     <= 1'b0;
      r_rd_sel     <= 1'b0;
      r_t          <= '0;
      r_state      <= ST_IDLE;
      r_out_valid  <= '0;
      r_done       <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        r_out_data[r] <= '0;
      end
    end else begin
      r_done      <= 1'b0;
      r_out_valid <= '0;
      if (w_load) begin
        r_bank_st[r_wr_sel] <= BANK_FULL;
        r_wr_sel            <= ~r_wr_sel;
      end
      case (r_state)
        ST_IDLE: begin
          if (r_bank_st[r_rd_sel] == BANK_FULL) begin
            r_bank_st[r_rd_sel] <= BANK_DRAIN;
            r_t                 <= '0;
            r_state             <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (i_en) begin
            for (int r = 0; r < ROWS; r++) begin
              r_out_data[r] <= w_row_vld[r] ? w_rd_sel[r] : '0;
            end
            r_out_valid <= w_row_vld;
            if (r_t == LAST_T) begin
              r_done              <= 1'b1;
              r_bank_st[r_rd_sel] <= BANK_EMPTY;
              r_rd_sel            <= ~r_rd_sel;
              r_t                 <= '0;
              // Chain straight into the other bank if it already holds a tile.
              if (r_bank_st[~r_rd_sel] == BANK_FULL) begin
                r_bank_st[~r_rd_sel] <= BANK_DRAIN;
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_t <= r_t + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_busy      = (r_state == ST_DRAIN);
  assign o_done      = r_done;
  assign o_dbg_state = r_state;

endmodule
